// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-side and return-address-stack-side signals of the program-counter
// sequencer, bundled so the sequencer and its environment share one port.
//
//   Stall, Op_Kind, Branch_Cond, Target, Resume : instruction control (to sequencer)
//   Ret_Add, Stack_Err                          : return-address stack results (to sequencer)
//   PC, NPPC                                    : current PC and PC+1 (from sequencer)
//   Stack_Enable, Stack_Write                   : stack strobe / push-not-pop (from sequencer)
//   Halted, Fault                               : status (from sequencer)
//   Issued_Push, Issued_Pop                     : strobe issued in the cycle just closed
//
// modport master : the sequencer itself
// modport slave  : the surrounding datapath / stack
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int PC_W = 13
);
   logic            Stall;
   logic [2:0]      Op_Kind;
   logic            Branch_Cond;
   logic [PC_W-1:0] Target;
   logic            Resume;
   logic [PC_W-1:0] Ret_Add;
   logic            Stack_Err;
   logic [PC_W-1:0] PC;
   logic [PC_W-1:0] NPPC;
   logic            Stack_Enable;
   logic            Stack_Write;
   logic            Halted;
   logic            Fault;
   logic            Issued_Push;
   logic            Issued_Pop;

   modport master (
      input  Stall, Op_Kind, Branch_Cond, Target, Resume, Ret_Add, Stack_Err,
      output PC, NPPC, Stack_Enable, Stack_Write, Halted, Fault,
             Issued_Push, Issued_Pop
   );

   modport slave (
      output Stall, Op_Kind, Branch_Cond, Target, Resume, Ret_Add, Stack_Err,
      input  PC, NPPC, Stack_Enable, Stack_Write, Halted, Fault,
             Issued_Push, Issued_Pop
   );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer. Holds PC, offers NPPC = PC+1 to the return-address
// stack, strobes the stack on CALL (push) / RET (pop) and loads PC from the
// jump/branch target or the popped return address. State updates on the rising
// edge of Slow_Clock; the stack acts on the falling edge, so a push/pop and its
// error flag are resolved by the rising edge that closes the cycle.
//
// Ports:
//   Slow_Clock : clock, rising edge
//   Reset      : asynchronous, active-high
//   bus        : pc_sequencer_if.master (instruction, stack and status signals)
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter int              PC_W     = 13,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic          Slow_Clock,
   input  logic          Reset,
   pc_sequencer_if.master bus
);

   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BRC  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            fault_q, fault_d;
   logic            issued_push_q, issued_push_d;
   logic            issued_pop_q, issued_pop_d;

   logic [PC_W-1:0] nppc;
   logic            is_stack_op;
   logic            strobe;

   // Natural wrap at 2^PC_W - 1 gives 0.
   assign nppc = pc_q + PC_W'(1);

   assign is_stack_op = (bus.Op_Kind == OP_CALL) || (bus.Op_Kind == OP_RET);

   // Strobe of the current cycle, before reset gating; this is also what
   // decides whether the closing edge samples Stack_Err.
   assign strobe = (state_q == ST_RUN) && !bus.Stall && is_stack_op;

   // Reset gates the strobe immediately so a reset landing between the rising
   // edge and the falling edge of a CALL/RET cycle cannot reach the stack.
   assign bus.Stack_Enable = strobe && !Reset;
   assign bus.Stack_Write  = strobe && !Reset && (bus.Op_Kind == OP_CALL);

   assign bus.PC          = pc_q;
   assign bus.NPPC        = nppc;
   assign bus.Halted      = halted_q;
   assign bus.Fault       = fault_q;
   assign bus.Issued_Push = issued_push_q;
   assign bus.Issued_Pop  = issued_pop_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      issued_push_d = issued_push_q;
      issued_pop_d  = issued_pop_q;

      // Stall freezes everything, including the issued-strobe flags.
      if (!bus.Stall) begin
         issued_push_d = strobe && (bus.Op_Kind == OP_CALL);
         issued_pop_d  = strobe && (bus.Op_Kind == OP_RET);

         unique case (state_q)
            ST_RUN: begin
               if (strobe && bus.Stack_Err) begin
                  // Failed push/pop: keep PC where the faulting CALL/RET sits.
                  state_d = ST_FAULT;
               end else begin
                  unique case (bus.Op_Kind)
                     OP_JMP:  pc_d = bus.Target;
                     OP_BRC:  pc_d = bus.Branch_Cond ? bus.Target : nppc;
                     OP_CALL: pc_d = bus.Target;
                     OP_RET:  pc_d = bus.Ret_Add;
                     OP_HALT: state_d = ST_HALT;
                     default: pc_d = nppc;   // SEQ and the unused codes 6-7
                  endcase
               end
            end
            ST_HALT: begin
               // PC is not advanced: the instruction at PC re-executes.
               if (bus.Resume) begin
                  state_d = ST_RUN;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_FAULT;
            end
         endcase
      end

      halted_d = (state_d == ST_HALT);
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge Slow_Clock or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         issued_push_q <= 1'b0;
         issued_pop_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
         issued_push_q <= issued_push_d;
         issued_pop_q  <= issued_pop_d;
      end
   end

   // OP_SEQ is covered by the default branch of the opcode decode.
   logic unused_seq;
   assign unused_seq = ^OP_SEQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed vectors for pc_sequencer. Each vector drives one clock cycle of
// inputs and pushes the hand-computed expected outputs for that cycle (PC as
// produced by the previous edge, plus this cycle's stack strobes) onto a
// scoreboard; a separate monitor pops and compares every cycle. A small
// behavioural return-address stack (depth 4) reacts on the falling edge and
// leaves Stack_Err stale between strobes.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
   localparam int PC_W = 13;

   localparam logic [2:0] SEQ  = 3'd0;
   localparam logic [2:0] JMP  = 3'd1;
   localparam logic [2:0] BRC  = 3'd2;
   localparam logic [2:0] CALL = 3'd3;
   localparam logic [2:0] RET  = 3'd4;
   localparam logic [2:0] HALT = 3'd5;

   logic clk;
   logic rst;

   pc_sequencer_if #(.PC_W(PC_W)) bus ();

   pc_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .Slow_Clock (clk),
      .Reset      (rst),
      .bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural return-address stack ----------------
   logic [PC_W-1:0] ret_add   = '0;
   logic            stack_err = 1'b0;
   logic [PC_W-1:0] stk[$];

   assign bus.Ret_Add   = ret_add;
   assign bus.Stack_Err = stack_err;

   always @(negedge clk) begin
      if (bus.Stack_Enable) begin
         if (bus.Stack_Write) begin
            if (stk.size() >= 4) begin
               stack_err <= 1'b1;
            end else begin
               stk.push_back(bus.NPPC);
               stack_err <= 1'b0;
            end
         end else begin
            if (stk.size() == 0) begin
               stack_err <= 1'b1;
            end else begin
               ret_add   <= stk.pop_back();
               stack_err <= 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      string           nm;
      logic [PC_W-1:0] pc;
      logic            en;
      logic            wr;
      logic            halt;
      logic            fault;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input string fld, input logic [PC_W-1:0] act,
                      input logic [PC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: samples 3 time units after each rising edge (inputs settle at +1/+2).
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.nm, "PC",    bus.PC, e.pc);
            chk(e.nm, "NPPC",  bus.NPPC, e.pc + 13'd1);
            chk(e.nm, "EN",    {12'd0, bus.Stack_Enable}, {12'd0, e.en});
            chk(e.nm, "WR",    {12'd0, bus.Stack_Write},  {12'd0, e.wr});
            chk(e.nm, "HALT",  {12'd0, bus.Halted},       {12'd0, e.halt});
            chk(e.nm, "FAULT", {12'd0, bus.Fault},        {12'd0, e.fault});
            $display("cycle %-10s op=%0d PC=0x%04h en=%0b wr=%0b halt=%0b fault=%0b",
                     e.nm, bus.Op_Kind, bus.PC, bus.Stack_Enable, bus.Stack_Write,
                     bus.Halted, bus.Fault);
         end
      end
   end

   // One cycle of stimulus; called at rising edge + 1. With mid_rst, Reset is
   // raised one time unit later, i.e. after the edge but before the falling edge.
   task automatic cyc(input logic r, input logic mid_rst, input logic [2:0] op,
                      input logic [PC_W-1:0] tgt, input logic cond, input logic stall,
                      input logic resume, input logic [PC_W-1:0] epc, input logic een,
                      input logic ewr, input logic ehalt, input logic efault,
                      input string nm);
      exp_t e;
      rst             = r;
      bus.Op_Kind     = op;
      bus.Target      = tgt;
      bus.Branch_Cond = cond;
      bus.Stall       = stall;
      bus.Resume      = resume;
      if (mid_rst) begin
         #1;
         rst = 1'b1;
      end
      e.nm = nm; e.pc = epc; e.en = een; e.wr = ewr; e.halt = ehalt; e.fault = efault;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      bus.Op_Kind     = SEQ;
      bus.Target      = '0;
      bus.Branch_Cond = 1'b0;
      bus.Stall       = 1'b0;
      bus.Resume      = 1'b0;
      @(posedge clk);
      #1;
      //   rst mid op    tgt      c  st rs  expPC    en wr h  f
      cyc(1, 0, CALL, 13'h100, 0, 0, 0, 13'h000, 0, 0, 0, 0, "reset");
      // 1: sequential run
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 0, "seq0");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h001, 0, 0, 0, 0, "seq1");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h002, 0, 0, 0, 0, "seq2");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h003, 0, 0, 0, 0, "seq3");
      cyc(0, 0, 3'd6, 13'h000, 0, 0, 0, 13'h004, 0, 0, 0, 0, "op6");
      // 2: CALL pushes 6, RET returns to 6
      cyc(0, 0, CALL, 13'h100, 0, 0, 0, 13'h005, 1, 1, 0, 0, "call");
      cyc(0, 0, RET,  13'h000, 0, 0, 0, 13'h100, 1, 0, 0, 0, "ret");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h006, 0, 0, 0, 0, "seq6");
      // 4: branches and stall
      cyc(0, 0, BRC,  13'h020, 0, 0, 0, 13'h007, 0, 0, 0, 0, "brc_nt");
      cyc(0, 0, BRC,  13'h020, 1, 0, 0, 13'h008, 0, 0, 0, 0, "brc_t");
      cyc(0, 0, CALL, 13'h300, 0, 1, 0, 13'h020, 0, 0, 0, 0, "stall");
      cyc(0, 0, JMP,  13'h1FFF,0, 0, 0, 13'h020, 0, 0, 0, 0, "jmp");
      // 5: wrap-around, HALT, Resume
      cyc(0, 0, 3'd7, 13'h000, 0, 0, 0, 13'h1FFF,0, 0, 0, 0, "wrap");
      cyc(0, 0, HALT, 13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 0, "halt");
      cyc(0, 0, CALL, 13'h100, 0, 0, 0, 13'h000, 0, 0, 1, 0, "halted1");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 1, 0, "halted2");
      cyc(0, 0, JMP,  13'h055, 0, 0, 0, 13'h000, 0, 0, 1, 0, "halted3");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 1, 13'h000, 0, 0, 1, 0, "resume");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 0, "reexec");
      // 3: RET on an empty stack faults; later ops ignored
      cyc(0, 0, RET,  13'h000, 0, 0, 0, 13'h001, 1, 0, 0, 0, "ret_empty");
      cyc(0, 0, CALL, 13'h100, 0, 0, 0, 13'h001, 0, 0, 0, 1, "fault1");
      cyc(0, 0, JMP,  13'h050, 0, 0, 1, 13'h001, 0, 0, 0, 1, "fault2");
      // Reset clears the fault; stale Stack_Err=1 must be ignored on SEQ
      cyc(1, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 0, "rst2");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 0, "stale0");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h001, 0, 0, 0, 0, "stale1");
      // 6: reset mid-CALL: PC=0 and no strobe at once, so nothing is pushed
      cyc(0, 1, CALL, 13'h100, 0, 0, 0, 13'h000, 0, 0, 0, 0, "mid_rst");
      cyc(0, 0, RET,  13'h000, 0, 0, 0, 13'h000, 1, 0, 0, 0, "ret_chk");
      cyc(0, 0, SEQ,  13'h000, 0, 0, 0, 13'h000, 0, 0, 0, 1, "fault3");

      for (int i = 0; i < 5 && sb.size() != 0; i++) begin
         @(posedge clk);
         #4;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
